result_argmax_fix7: RTL and testbench

RESULT_ARGMAX_FIX7 -- requirements
Module: result_argmax_fix7

---
 rtl/mnist_pkg.sv | 13 +
 rtl/result_argmax_fix7.sv | 95 +++++++++
 tb/tb_result_argmax_fix7.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mnist_pkg.sv
// Shared constants and FSM state type for the MNIST result argmax block.
package mnist_pkg;

    localparam int DATA_WIDTH  = 7;
    localparam int NUM_CLASSES = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } argmax_state_t;

endpackage

// File: rtl/result_argmax_fix7.sv
// Scans the engine's class scores one per cycle and holds the argmax until accepted.
// Optional RESULT_ARGMAX_SCORE_EN adds the max_score output.
module result_argmax_fix7 #(
    parameter int DATA_WIDTH  = mnist_pkg::DATA_WIDTH,
    parameter int NUM_CLASSES = mnist_pkg::NUM_CLASSES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         done,
    output logic [3:0]                   out_idx,
    input  logic signed [DATA_WIDTH-1:0] out,
    output logic [3:0]                   digit,
    output logic                         valid,
    input  logic                         ready,
`ifdef RESULT_ARGMAX_SCORE_EN
    output logic signed [DATA_WIDTH-1:0] max_score,
`endif
    output logic                         busy
);
    import mnist_pkg::*;

    localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

    argmax_state_t               state;
    logic                        done_q;
    logic signed [DATA_WIDTH-1:0] max_q;
    logic [3:0]                  best_idx;
    logic                        start;
    logic                        take;

    assign start = done && !done_q;
    // Index 0 always loads; later scores win only when strictly greater.
    assign take  = (out_idx == '0) || (out > max_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            out_idx  <= '0;
            digit    <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            max_q    <= '0;
            best_idx <= '0;
`ifdef RESULT_ARGMAX_SCORE_EN
            max_score <= '0;
`endif
        end else begin
            done_q <= done;
            unique case (state)
                IDLE: begin
                    out_idx <= '0;
                    busy    <= 1'b0;
                    if (start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (take) begin
                        max_q    <= out;
                        best_idx <= out_idx;
                    end
                    if (out_idx == LAST_IDX) begin
                        state   <= HOLD;
                        busy    <= 1'b0;
                        out_idx <= '0;
                        valid   <= 1'b1;
                        // Final sample folds in here rather than a cycle later.
                        digit   <= take ? out_idx : best_idx;
`ifdef RESULT_ARGMAX_SCORE_EN
                        max_score <= take ? out : max_q;
`endif
                    end else begin
                        out_idx <= out_idx + 4'd1;
                    end
                end
                HOLD: begin
                    out_idx <= '0;
                    if (ready) begin
                        state <= IDLE;
                        valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    out_idx <= '0;
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_argmax_fix7.sv
// Self-checking bench for result_argmax_fix7: table runs, hold/ready, ignored restarts, reset mid-scan.
module tb_result_argmax_fix7;

    localparam int DW = 7;
    localparam int NC = 10;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 done = 1'b0;
    logic                 ready = 1'b0;
    logic [3:0]           out_idx;
    logic signed [DW-1:0] out;
    logic [3:0]           digit;
    logic                 valid;
    logic                 busy;
`ifdef RESULT_ARGMAX_SCORE_EN
    logic signed [DW-1:0] max_score;
`endif

    logic signed [DW-1:0] sc [NC];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;

    typedef struct {
        logic [NC-1:0][DW-1:0] s;
        int                    d;
        int                    m;
    } vec_t;

    typedef struct {
        int d;
        int m;
    } exp_t;

    exp_t sb [$];
    vec_t vecs [6];

    always #5 clk = ~clk;

    assign out = (out_idx < 4'(NC)) ? sc[out_idx] : '0;

    result_argmax_fix7 #(.DATA_WIDTH(DW), .NUM_CLASSES(NC)) dut (
        .clk(clk),
        .rst(rst),
        .done(done),
        .out_idx(out_idx),
        .out(out),
        .digit(digit),
        .valid(valid),
        .ready(ready),
`ifdef RESULT_ARGMAX_SCORE_EN
        .max_score(max_score),
`endif
        .busy(busy)
    );

    always @(negedge clk) begin
        if (!rst) begin
            total++;
            if (out_idx > 4'd9) begin
                bad++;
                $display("FAIL idx_range: out_idx=%0d required <= 9", out_idx);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int r [NC], input int d, input int m);
        vec_t v;
        for (int i = 0; i < NC; i++) v.s[i] = DW'(r[i]);
        v.d = d;
        v.m = m;
        return v;
    endfunction

    function automatic exp_t ref_argmax(input vec_t v);
        exp_t e;
        e.d = 0;
        e.m = int'($signed(v.s[0]));
        for (int i = 1; i < NC; i++)
            if (int'($signed(v.s[i])) > e.m) begin
                e.d = i;
                e.m = int'($signed(v.s[i]));
            end
        return e;
    endfunction

    task automatic load(input vec_t v);
        for (int i = 0; i < NC; i++) sc[i] = $signed(v.s[i]);
    endtask

    // Raises done, pushes the expectation, and steps through E0.
    task automatic start(input vec_t v);
        exp_t e;
        load(v);
        e.d = v.d;
        e.m = v.m;
        sb.push_back(e);
        done = 1'b1;
        tick();
        t0 = cyc;
        chk("busy_after_start", int'(busy), 1);
        chk("idx_after_start", int'(out_idx), 0);
    endtask

    task automatic wait_result(input string tag);
        exp_t e;
        int n = 0;
        while (!valid && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, int'(valid), 1);
        chk({tag, "_latency"}, cyc - t0, 10);
        chk({tag, "_busy_in_hold"}, int'(busy), 0);
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s_scoreboard: got empty queue required an entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_digit"}, int'(digit), e.d);
`ifdef RESULT_ARGMAX_SCORE_EN
            chk({tag, "_max_score"}, int'(max_score), e.m);
`endif
        end
    endtask

    task automatic release_result(input string tag);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk({tag, "_valid_cleared"}, int'(valid), 0);
    endtask

    initial begin
        int r [NC];
        vec_t v;
        exp_t e;

        for (int i = 0; i < NC; i++) sc[i] = '0;

        r = '{3, -5, 12, 7, 0, -64, 11, 12, 1, 2};   vecs[0] = mk(r, 2, 12);
        r = '{-64, -64, -64, -64, -64, -64, -64, -64, -64, -64}; vecs[1] = mk(r, 0, -64);
        r = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 63};        vecs[2] = mk(r, 9, 63);
        r = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};         vecs[3] = mk(r, 0, 1);
        r = '{-64, -64, -64, -64, -64, 63, -64, -64, -64, -64}; vecs[4] = mk(r, 5, 63);
        r = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10}; vecs[5] = mk(r, 0, -1);

        tick();
        tick();
        chk("rst_valid", int'(valid), 0);
        chk("rst_digit", int'(digit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_idx", int'(out_idx), 0);
`ifdef RESULT_ARGMAX_SCORE_EN
        chk("rst_max_score", int'(max_score), 0);
`endif
        rst = 1'b0;
        tick();

        for (int k = 0; k < 6; k++) begin
            start(vecs[k]);
            done = 1'b0;
            wait_result($sformatf("vec%0d", k));
            release_result($sformatf("vec%0d", k));
        end

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NC; i++) r[i] = int'($urandom_range(0, 127)) - 64;
            v = mk(r, 0, 0);
            e = ref_argmax(v);
            v.d = e.d;
            v.m = e.m;
            start(v);
            done = 1'b0;
            wait_result($sformatf("rnd%0d", k));
            release_result($sformatf("rnd%0d", k));
        end

        // Long hold with done kept high: result stable, no retrigger after release.
        start(vecs[0]);
        wait_result("hold");
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_valid_stable", int'(valid), 1);
            chk("hold_digit_stable", int'(digit), 2);
        end
        release_result("hold");
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("hold_no_retrigger_busy", int'(busy), 0);
            chk("hold_no_retrigger_valid", int'(valid), 0);
        end
        done = 1'b0;
        tick();

        // Second done rise at E4 is ignored and not queued.
        start(vecs[0]);
        done = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        wait_result("pulse_e4");
        release_result("pulse_e4");
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("pulse_e4_no_queued_scan", int'(busy), 0);
        end

        // Reset at E5 with done high: result discarded, new scan right after rst falls.
        start(vecs[2]);
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        void'(sb.pop_back());
        chk("midrst_valid", int'(valid), 0);
        chk("midrst_digit", int'(digit), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_idx", int'(out_idx), 0);
`ifdef RESULT_ARGMAX_SCORE_EN
        chk("midrst_max_score", int'(max_score), 0);
`endif
        rst = 1'b0;
        load(vecs[3]);
        e.d = vecs[3].d;
        e.m = vecs[3].m;
        sb.push_back(e);
        tick();
        t0 = cyc;
        chk("rst_restart_busy", int'(busy), 1);
        done = 1'b0;
        wait_result("rst_restart");
        release_result("rst_restart");

        chk("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
